decoder_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 3-to-8 enable decoder. It generates the 3-bit select code and the enable that drive that decoder. On a start request it walks through a masked set of the eight decoder outputs, holding each for a programmable dwell time. A one-cycle break-before-make gap separates channels. It runs either one sweep or continuously until stopped.

---
 rtl/decoder_scan_ctrl.sv | 155 +++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - select/enable sequencer for a 3-to-8 enable decoder
// Walks the captured channel mask with a programmable dwell and a one-cycle gap between channels.
module decoder_scan_ctrl #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic               mode_cont,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [7:0]         mask,
   output logic [2:0]         sel,
   output logic               en,
   output logic               busy,
   output logic               step,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

   state_t             state, state_nxt;
   logic [DWELL_W-1:0] cnt, cnt_nxt;
   logic [DWELL_W-1:0] cfg_d, cfg_d_nxt;
   logic [7:0]         cfg_mask, cfg_mask_nxt;
   logic               cfg_cont, cfg_cont_nxt;
   logic [2:0]         sel_nxt;
   logic               en_nxt, busy_nxt, step_nxt, done_nxt;
   logic [DWELL_W-1:0] dwell_eff;
   logic [3:0]         next_ch;

   function automatic logic [2:0] lowest_set(input logic [7:0] m);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowest_set = 3'(i);
   endfunction

   // {found, index} of the lowest set bit strictly above cur
   function automatic logic [3:0] next_set(input logic [7:0] m, input logic [2:0] cur);
      next_set = 4'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i] && (3'(i) > cur)) next_set = {1'b1, 3'(i)};
   endfunction

   assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign next_ch   = next_set(cfg_mask, sel);

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      cfg_d_nxt    = cfg_d;
      cfg_mask_nxt = cfg_mask;
      cfg_cont_nxt = cfg_cont;
      sel_nxt      = sel;
      en_nxt       = en;
      busy_nxt     = busy;
      step_nxt     = 1'b0;
      done_nxt     = 1'b0;

      case (state)
         IDLE: begin
            sel_nxt  = 3'd0;
            en_nxt   = 1'b0;
            busy_nxt = 1'b0;
            if (start && !stop) begin
               if (mask == 8'd0) begin
                  done_nxt = 1'b1;
               end else begin
                  state_nxt    = SCAN;
                  cfg_mask_nxt = mask;
                  cfg_cont_nxt = mode_cont;
                  cfg_d_nxt    = dwell_eff;
                  cnt_nxt      = dwell_eff;
                  sel_nxt      = lowest_set(mask);
                  en_nxt       = 1'b1;
                  busy_nxt     = 1'b1;
                  step_nxt     = 1'b1;
               end
            end
         end
         SCAN: begin
            if (cnt > DWELL_W'(1)) begin
               cnt_nxt = cnt - DWELL_W'(1);
            end else if (next_ch[3]) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
               en_nxt    = 1'b0;
               sel_nxt   = next_ch[2:0];
            end else if (cfg_cont) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
               en_nxt    = 1'b0;
               sel_nxt   = lowest_set(cfg_mask);
            end else begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               en_nxt    = 1'b0;
               sel_nxt   = 3'd0;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end
         end
         GAP: begin
            state_nxt = SCAN;
            cnt_nxt   = cfg_d;
            en_nxt    = 1'b1;
            step_nxt  = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            en_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            sel_nxt   = 3'd0;
         end
      endcase

      // abort overrides everything once a sweep is in progress
      if (stop && (state != IDLE)) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         sel_nxt   = 3'd0;
         en_nxt    = 1'b0;
         busy_nxt  = 1'b0;
         step_nxt  = 1'b0;
         done_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         cfg_d    <= '0;
         cfg_mask <= 8'd0;
         cfg_cont <= 1'b0;
         sel      <= 3'd0;
         en       <= 1'b0;
         busy     <= 1'b0;
         step     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         cfg_d    <= cfg_d_nxt;
         cfg_mask <= cfg_mask_nxt;
         cfg_cont <= cfg_cont_nxt;
         sel      <= sel_nxt;
         en       <= en_nxt;
         busy     <= busy_nxt;
         step     <= step_nxt;
         done     <= done_nxt;
      end
   end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - self-checking bench for decoder_scan_ctrl
// Per-cycle traces are predicted from the channel list built out of the mask.
module tb_decoder_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, start, stop, mode_cont;
   logic [7:0] dwell, mask;
   logic [2:0] sel;
   logic       en, busy, step, done;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0] exp_q[$];
   logic [6:0] obs_q[$];

   always #5 clk = ~clk;

   decoder_scan_ctrl #(.DWELL_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .mode_cont(mode_cont), .dwell(dwell), .mask(mask),
      .sel(sel), .en(en), .busy(busy), .step(step), .done(done)
   );

   function automatic logic [6:0] pk(int s, bit e, bit b, bit st, bit d);
      logic [2:0] s3;
      s3 = 3'(s);
      return {s3, e, b, st, d};
   endfunction

   // Expected trace: each listed channel enabled for D cycles, a gap showing the next channel,
   // done after the last channel of a single sweep, idle once stopped.
   task automatic model(input logic [7:0] m, input logic [7:0] dw, input bit cont,
                        input int ncyc, input int stop_at);
      int chans[$];
      int d, n, k;
      exp_q.delete();
      d = (dw == 0) ? 1 : int'(dw);
      for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
      n = chans.size();
      if (n == 0) begin
         exp_q.push_back(pk(0, 0, 0, 0, 1));
      end else begin
         k = 0;
         while (exp_q.size() < ncyc) begin
            for (int j = 0; j < d; j++) exp_q.push_back(pk(chans[k % n], 1, 1, j == 0, 0));
            if ((k % n == n - 1) && !cont) begin
               exp_q.push_back(pk(0, 0, 0, 0, 1));
               break;
            end
            exp_q.push_back(pk(chans[(k + 1) % n], 0, 1, 0, 0));
            k++;
         end
      end
      while (exp_q.size() < ncyc) exp_q.push_back(pk(0, 0, 0, 0, 0));
      if (stop_at >= 0)
         for (int i = stop_at + 1; i < ncyc; i++) exp_q[i] = pk(0, 0, 0, 0, 0);
   endtask

   // Pulses start with the given config and records ncyc cycles beginning one cycle after the start edge.
   task automatic drive_scan(input logic [7:0] m, input logic [7:0] dw, input bit cont,
                             input int ncyc, input int stop_at, input int chg_at);
      obs_q.delete();
      @(negedge clk);
      mask = m; dwell = dw; mode_cont = cont; start = 1'b1; stop = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         start = 1'b0;
         stop  = 1'b0;
         obs_q.push_back({sel, en, busy, step, done});
         if (i == stop_at) stop = 1'b1;
         if (i == chg_at) begin
            mask = 8'h01; dwell = 8'd9; mode_cont = ~cont; start = 1'b1;
         end
      end
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; dwell = 8'd0; mask = 8'd0;
      #12;
      vectors++;
      if ({sel, en, busy, step, done} !== 7'd0) begin
         miscompares++;
         $display("FAIL reset: got %b want %b", {sel, en, busy, step, done}, 7'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_sweep();
      model(8'hFF, 8'd2, 1'b0, 26, -1);
      drive_scan(8'hFF, 8'd2, 1'b0, 26, -1, 5);
      for (int i = 0; i < 26; i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL full_sweep cyc %0d: got {sel,en,busy,step,done}=%b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_sparse();
      model(8'b1010_0100, 8'd1, 1'b0, 8, -1);
      drive_scan(8'b1010_0100, 8'd1, 1'b0, 8, -1, -1);
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL sparse cyc %0d: got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_cont_stop();
      model(8'h81, 8'd3, 1'b1, 20, 9);
      drive_scan(8'h81, 8'd3, 1'b1, 20, 9, -1);
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL cont_stop cyc %0d: got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_corners();
      model(8'h10, 8'd0, 1'b0, 4, -1);
      drive_scan(8'h10, 8'd0, 1'b0, 4, -1, -1);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL dwell_zero cyc %0d: got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
      model(8'h00, 8'd3, 1'b0, 3, -1);
      drive_scan(8'h00, 8'd3, 1'b0, 3, -1, -1);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (obs_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL mask_zero cyc %0d: got %b want %b", i, obs_q[i], exp_q[i]);
         end
      end
      @(negedge clk);
      mask = 8'hFF; dwell = 8'd1; start = 1'b1; stop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = 1'b0; stop = 1'b0;
         vectors++;
         if ({sel, en, busy, step, done} !== 7'd0) begin
            miscompares++;
            $display("FAIL start_stop_idle cyc %0d: got %b want %b", i, {sel, en, busy, step, done}, 7'd0);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] m, dw;
      bit         cont;
      int         n, ncyc, sa;
      for (int t = 0; t < 10; t++) begin
         m    = 8'($urandom_range(0, 255));
         dw   = 8'($urandom_range(0, 3));
         cont = (t % 3 == 2);
         n    = $countones(m);
         if (cont) begin
            ncyc = 30;
            sa   = $urandom_range(1, 24);
         end else begin
            ncyc = (n == 0) ? 3 : n * ((dw == 0) ? 1 : int'(dw)) + (n - 1) + 3;
            sa   = -1;
         end
         model(m, dw, cont, ncyc, sa);
         drive_scan(m, dw, cont, ncyc, sa, -1);
         for (int i = 0; i < ncyc; i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL random t%0d mask=%h dwell=%0d cont=%0d cyc %0d: got %b want %b",
                        t, m, dw, cont, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      mask = 8'hFF; dwell = 8'd5; mode_cont = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if ({sel, en, busy} !== {3'd0, 1'b1, 1'b1}) begin
         miscompares++;
         $display("FAIL pre_reset: got sel=%0d en=%b busy=%b want sel=0 en=1 busy=1", sel, en, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({sel, en, busy, step, done} !== 7'd0) begin
         miscompares++;
         $display("FAIL async_reset: got %b want %b", {sel, en, busy, step, done}, 7'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if ({sel, en, busy, step, done} !== 7'd0) begin
            miscompares++;
            $display("FAIL post_reset_idle cyc %0d: got %b want %b", i, {sel, en, busy, step, done}, 7'd0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_sweep();
      test_sparse();
      test_cont_stop();
      test_corners();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
